timer_tick_sequencer: RTL and testbench
=======================================

TIMER_TICK_SEQUENCER -- requirements
Module: timer_tick_sequencer

Interface
REQ-001 SHALL have parameter TICK_W, default 16, width of tick_target and tick_count.
REQ-002 SHALL have parameter CTRL_RUN, default 16'h0007, control word written to start the timer (ITO|CONT|START).
REQ-003 SHALL have parameter CTRL_STOP, default 16'h0008, control word written to stop the timer (STOP).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port cmd_start, input, 1, single-cycle request to begin a tick run.
REQ-007 SHALL have port cmd_stop, input, 1, single-cycle request to abort a run.
REQ-008 SHALL have port tick_target, input, TICK_W, timeouts per run; 0 = free-run; sampled on accepted cmd_start.
REQ-009 SHALL have port tmr_irq, input, 1, timer interrupt.
REQ-010 SHALL have port tmr_readdata, input, 16, timer read data, valid one cycle after address is presented.
REQ-011 SHALL have ports tmr_address (output, 3), tmr_chipselect (output, 1), tmr_write_n (output, 1), tmr_writedata (output, 16): Avalon master to the timer slave, no waitrequest, single-cycle transfers.
REQ-012 SHALL have outputs busy (1), done (1), tick_pulse (1), overflow (1), tick_count (TICK_W).

Function
REQ-013 SHALL implement FSM states IDLE, START, WAIT_IRQ, CLEAR, VERIFY, VERIFY_WAIT, STOP.
REQ-014 IDLE: cmd_start=1 and cmd_stop=0 -> latch tick_target, clear tick_count and overflow, go to START; cmd_stop wins when both asserted (remain IDLE, no bus activity).
REQ-015 START: one cycle, chipselect=1, write_n=0, address=1, writedata=CTRL_RUN; next state WAIT_IRQ.
REQ-016 WAIT_IRQ: bus idle (chipselect=0, write_n=1); tmr_irq=1 -> CLEAR.
REQ-017 CLEAR: one-cycle write to address 0, writedata 0; tick_count increments by 1, tick_pulse=1 for this cycle; next VERIFY.
REQ-018 VERIFY: one-cycle read, chipselect=1, write_n=1, address=0; next VERIFY_WAIT.
REQ-019 VERIFY_WAIT: sample tmr_readdata[0]; if 1 (a new timeout latched) -> CLEAR; else if target!=0 and tick_count==target -> STOP; else -> WAIT_IRQ.
REQ-020 STOP: one-cycle write to address 1, writedata CTRL_STOP; next IDLE; done=1 for exactly this cycle.
REQ-021 cmd_stop in START, WAIT_IRQ, CLEAR, VERIFY or VERIFY_WAIT -> complete the current cycle's transfer, then STOP next cycle; cmd_stop in STOP ignored.
REQ-022 cmd_start while not IDLE SHALL be ignored (no relatch, no count reset).
REQ-023 tick_count SHALL wrap modulo 2^TICK_W; on wrap from all-ones to 0, overflow sets and stays set until next accepted start or reset.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 tick_count and overflow SHALL hold their values in IDLE after a run until the next accepted start.
REQ-026 In any state without a transfer, outputs SHALL be chipselect=0, write_n=1, address=0, writedata=0.
REQ-027 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to tmr_* outputs.

Reset
REQ-028 reset_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, tick_pulse=0, overflow=0, tick_count=0, chipselect=0, write_n=1, address=0, writedata=0, regardless of current state.
REQ-029 Reset mid-run SHALL NOT issue a STOP write; the timer is reset by its own reset.
REQ-030 First cmd_start SHALL be accepted on the first edge with reset_n=1.

Verification
REQ-031 tick_target=3, cmd_start, irq model pulses thrice -> 1 write addr1=0x0007, 3x (write addr0=0, read addr0), write addr1=0x0008, done one cycle, tick_count=3.
REQ-032 tick_target=0, 5 irqs then cmd_stop in WAIT_IRQ -> tick_count=5, STOP write next cycle, done pulse, busy=0.
REQ-033 tmr_readdata[0]=1 on first VERIFY_WAIT -> second CLEAR write issued, tick_count advances by 2 for that irq.
REQ-034 cmd_start and cmd_stop same cycle in IDLE -> no bus transfer, busy stays 0.
REQ-035 TICK_W=4, target=0, 17 irqs -> tick_count=1, overflow=1.
REQ-036 reset_n=0 during WAIT_IRQ with tick_count=2 -> next cycle all outputs at reset values, no STOP write observed.

Source files
------------

// File: rtl/timer_tick_sequencer.sv
// Drives an interval-timer slave over an Avalon master port: starts it, acknowledges each
// timeout, counts the ticks and stops the timer after a target count or on request.
module timer_tick_sequencer #(
    parameter int unsigned TICK_W    = 16,
    parameter logic [15:0] CTRL_RUN  = 16'h0007,
    parameter logic [15:0] CTRL_STOP = 16'h0008
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic [TICK_W-1:0] tick_target,
    input  logic              tmr_irq,
    input  logic [15:0]       tmr_readdata,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    output logic              busy,
    output logic              done,
    output logic              tick_pulse,
    output logic              overflow,
    output logic [TICK_W-1:0] tick_count
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitIrq,
        StClear,
        StVerify,
        StVerifyWait,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [TICK_W-1:0] target_q, target_d;
    logic [TICK_W-1:0] count_q, count_d;
    logic              ovf_q, ovf_d;

    // Only the timeout status bit of the status register matters here.
    logic unused_readdata;
    assign unused_readdata = ^tmr_readdata[15:1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            target_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_start && !cmd_stop) begin
                    target_d = tick_target;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                    state_d  = StStart;
                end
            end
            StStart: state_d = cmd_stop ? StStop : StWaitIrq;
            StWaitIrq: begin
                if (cmd_stop) begin
                    state_d = StStop;
                end else if (tmr_irq) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                count_d = count_q + TICK_W'(1);
                if (&count_q) begin
                    ovf_d = 1'b1;
                end
                state_d = cmd_stop ? StStop : StVerify;
            end
            StVerify: state_d = cmd_stop ? StStop : StVerifyWait;
            StVerifyWait: begin
                // A timeout latched during the acknowledge must be cleared again.
                if (cmd_stop) begin
                    state_d = StStop;
                end else if (tmr_readdata[0]) begin
                    state_d = StClear;
                end else if (target_q != '0 && count_q == target_q) begin
                    state_d = StStop;
                end else begin
                    state_d = StWaitIrq;
                end
            end
            StStop:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        unique case (state_q)
            StStart: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = CTRL_RUN;
            end
            StClear: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
            end
            StVerify: begin
                tmr_chipselect = 1'b1;
            end
            StStop: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = CTRL_STOP;
            end
            default: begin
            end
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StStop);
    assign tick_pulse = (state_q == StClear);
    assign overflow   = ovf_q;
    assign tick_count = count_q;

endmodule

// File: tb/tb_timer_tick_sequencer.sv
// Randomized bench for timer_tick_sequencer: a behavioural timer slave answers the bus and a
// transaction-level model predicts the transfer list, final count and overflow of each run.
module tb_timer_tick_sequencer;

    localparam int TW = 4;
    localparam logic [19:0] TrRun  = {1'b0, 3'd1, 16'h0007};
    localparam logic [19:0] TrStop = {1'b0, 3'd1, 16'h0008};
    localparam logic [19:0] TrClr  = {1'b0, 3'd0, 16'h0000};
    localparam logic [19:0] TrRd   = {1'b1, 3'd0, 16'h0000};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_stop = 1'b0;
    logic [TW-1:0] tick_target = '0;
    logic          tmr_irq;
    logic [15:0]   tmr_readdata;
    logic [2:0]    tmr_address;
    logic          tmr_chipselect;
    logic          tmr_write_n;
    logic [15:0]   tmr_writedata;
    logic          busy, done, tick_pulse, overflow;
    logic [TW-1:0] tick_count;

    int n_chk = 0;
    int n_pass = 0;
    int done_total = 0;
    logic [19:0] obs[$];

    // Timer slave model
    logic        inject = 1'b0;
    logic        inject_dbl = 1'b0;
    logic        to_q = 1'b0;
    logic        dbl_arm = 1'b0;
    logic [15:0] rd_q = '0;

    timer_tick_sequencer #(.TICK_W(TW)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_start     (cmd_start),
        .cmd_stop      (cmd_stop),
        .tick_target   (tick_target),
        .tmr_irq       (tmr_irq),
        .tmr_readdata  (tmr_readdata),
        .tmr_address   (tmr_address),
        .tmr_chipselect(tmr_chipselect),
        .tmr_write_n   (tmr_write_n),
        .tmr_writedata (tmr_writedata),
        .busy          (busy),
        .done          (done),
        .tick_pulse    (tick_pulse),
        .overflow      (overflow),
        .tick_count    (tick_count)
    );

    always #5 clk = ~clk;

    assign tmr_irq      = to_q;
    assign tmr_readdata = rd_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Status bit: set by an injected timeout, cleared by a write to address 0 unless a second
    // timeout was armed to land right behind the acknowledge.
    always @(posedge clk) begin
        if (!reset_n) begin
            to_q    <= 1'b0;
            dbl_arm <= 1'b0;
            rd_q    <= '0;
        end else begin
            rd_q <= {15'($urandom), to_q};
            if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) begin
                to_q    <= dbl_arm;
                dbl_arm <= 1'b0;
            end else if (inject) begin
                to_q    <= 1'b1;
                dbl_arm <= inject_dbl;
            end
        end
    end

    always @(negedge clk) begin
        if (!tmr_chipselect) begin
            check("idle_bus", {12'h0, tmr_write_n, tmr_address, tmr_writedata},
                  {12'h0, 1'b1, 3'd0, 16'h0});
        end else begin
            obs.push_back({tmr_write_n, tmr_address, tmr_write_n ? 16'h0 : tmr_writedata});
        end
        check("done_is_stop", 32'(done),
              32'(tmr_chipselect && !tmr_write_n && tmr_address == 3'd1 && !busy) | 32'(done && busy
              && tmr_chipselect && !tmr_write_n && tmr_address == 3'd1 && tmr_writedata == 16'h8));
        check("pulse_is_clear", 32'(tick_pulse),
              32'(tmr_chipselect && !tmr_write_n && tmr_address == 3'd0));
        if (done) done_total++;
    end

    task automatic wait_to_clear();
        int g = 0;
        while (to_q && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("irq_ack_timeout", 32'(g), 32'(0));
    endtask

    // dbl_mode: 0 random doubles, 1 double on first timeout, 2 never double.
    task automatic do_run(input int target, input int total, input bit stop, input int dbl_mode);
        int rem;
        int base;
        int dbase;
        int g;
        bit dbl;
        logic [19:0] exp_q[$];
        base  = obs.size();
        dbase = done_total;
        tick_target = TW'(target);
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        tick_target = TW'($urandom);
        repeat (2) @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
            cmd_start = 1'b1;
            @(negedge clk);
            cmd_start = 1'b0;
        end
        rem = total;
        while (rem > 0) begin
            dbl = (rem >= 2) && ((dbl_mode == 1 && rem == total) ||
                                 (dbl_mode == 0 && $urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_to_clear();
            inject = 1'b1;
            inject_dbl = dbl;
            @(negedge clk);
            inject = 1'b0;
            inject_dbl = 1'b0;
            rem -= dbl ? 2 : 1;
        end
        if (stop) begin
            wait_to_clear();
            repeat (6) @(negedge clk);
            cmd_stop = 1'b1;
            @(negedge clk);
            cmd_stop = 1'b0;
            check("stop_next_cycle", {31'h0, done}, 32'(1));
        end
        g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("run_end_timeout", 32'(g), 32'(0));
        repeat (3) @(negedge clk);
        exp_q.push_back(TrRun);
        for (int i = 0; i < total; i++) begin
            exp_q.push_back(TrClr);
            exp_q.push_back(TrRd);
        end
        exp_q.push_back(TrStop);
        check("busy_end", {31'h0, busy}, 32'(0));
        check("done_pulses", 32'(done_total - dbase), 32'(1));
        check("tick_count", 32'(tick_count), 32'(total % (1 << TW)));
        check("overflow", {31'h0, overflow}, 32'(total >= (1 << TW)));
        check("xfer_count", 32'(obs.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < obs.size(); i++) begin
            check("xfer", 32'(obs[base+i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        int base;
        int nstop;
        int tgt, tot;
        bit st;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'(0));
        check("rst_flags", {29'h0, done, tick_pulse, overflow}, 32'(0));
        check("rst_count", 32'(tick_count), 32'(0));
        check("rst_bus", {12'h0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
              {12'h0, 1'b0, 1'b1, 3'd0, 16'h0});

        // First start coincides with reset release.
        reset_n = 1'b1;
        do_run(3, 3, 1'b0, 2);
        do_run(0, 5, 1'b1, 2);
        do_run(0, 2, 1'b1, 1);

        base = obs.size();
        cmd_start = 1'b1;
        cmd_stop = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_stop = 1'b0;
        repeat (4) @(negedge clk);
        check("both_cmd_busy", {31'h0, busy}, 32'(0));
        check("both_cmd_xfers", 32'(obs.size() - base), 32'(0));

        do_run(0, 17, 1'b1, 2);

        for (int r = 0; r < 12; r++) begin
            tgt = $urandom_range(0, 7);
            if (tgt == 0) begin
                tot = $urandom_range(0, 20);
                st = 1'b1;
            end else if ($urandom_range(0, 2) == 0) begin
                tot = $urandom_range(0, tgt - 1);
                st = 1'b1;
            end else begin
                tot = tgt;
                st = 1'b0;
            end
            do_run(tgt, tot, st, 0);
        end

        // Reset in the middle of a free run with two ticks counted.
        base = obs.size();
        tick_target = '0;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            repeat (2) @(negedge clk);
            wait_to_clear();
            inject = 1'b1;
            @(negedge clk);
            inject = 1'b0;
        end
        wait_to_clear();
        repeat (6) @(negedge clk);
        check("pre_rst_count", 32'(tick_count), 32'(2));
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'h0, busy}, 32'(0));
        check("mid_rst_flags", {29'h0, done, tick_pulse, overflow}, 32'(0));
        check("mid_rst_count", 32'(tick_count), 32'(0));
        check("mid_rst_bus", {12'h0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
              {12'h0, 1'b0, 1'b1, 3'd0, 16'h0});
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        nstop = 0;
        for (int i = base; i < obs.size(); i++) begin
            if (obs[i] == TrStop) nstop++;
        end
        check("mid_rst_no_stop", 32'(nstop), 32'(0));
        check("mid_rst_idle", {31'h0, busy}, 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
